// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/stall handling
// and a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_rd_wren,
  input  logic              id_mem_rd,
  input  logic              id_mem_wren,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              ex_valid,
  output logic              ex_rd_wren,
  output logic              ex_mem_rd,
  output logic              ex_mem_wren,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic              hold_req,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              r_valid;
  logic              r_rd_wren;
  logic              r_mem_rd;
  logic              r_mem_wren;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [DATA_W-1:0] r_imm;
  logic [CTRL_W-1:0] r_ctrl;
  logic [RA_W-1:0]   r_rs1;
  logic [RA_W-1:0]   r_rs2;
  logic [RA_W-1:0]   r_rd;
  logic [CNT_W-1:0]  r_cnt;

  logic w_load_use;
  logic w_bubble;
  logic w_cnt_sat;

  // A load in EX whose result is needed by the instruction in ID; x0 never counts.
  always_comb begin
    w_load_use = r_valid & r_mem_rd & (r_rd != '0) & id_valid &
                 ((r_rd == id_rs1) | (r_rd == id_rs2));
    w_bubble   = flush | (~ex_stall & w_load_use);
    w_cnt_sat  = (r_cnt == '1);
  end

  assign hold_req = ~flush & (ex_stall | w_load_use);

  // Payload only moves on a normal load; control bits are cleared on flush/bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_rd_wren  <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_wren <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_ctrl     <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (flush || (!ex_stall && w_load_use)) begin
      r_valid    <= 1'b0;
      r_rd_wren  <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_wren <= 1'b0;
    end else if (!ex_stall) begin
      r_valid    <= id_valid;
      r_rd_wren  <= id_rd_wren & id_valid;
      r_mem_rd   <= id_mem_rd & id_valid;
      r_mem_wren <= id_mem_wren & id_valid;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_ctrl     <= id_ctrl;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
    end
  end

  // Saturating bubble counter; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_bubble && !w_cnt_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign ex_valid    = r_valid;
  assign ex_rd_wren  = r_rd_wren;
  assign ex_mem_rd   = r_mem_rd;
  assign ex_mem_wren = r_mem_wren;
  assign ex_pc       = r_pc;
  assign ex_rs1_data = r_rs1_data;
  assign ex_rs2_data = r_rs2_data;
  assign ex_imm      = r_imm;
  assign ex_ctrl     = r_ctrl;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;
  assign bubble_cnt  = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; a second instance with a
// 2-bit bubble counter exercises saturation.
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned RA_W   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [DATA_W-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [RA_W-1:0]   id_rs1, id_rs2, id_rd;
  logic              id_rd_wren, id_mem_rd, id_mem_wren;
  logic              ex_stall, flush, cnt_clr;

  logic              ex_valid, ex_rd_wren, ex_mem_rd, ex_mem_wren;
  logic [DATA_W-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [RA_W-1:0]   ex_rs1, ex_rs2, ex_rd;
  logic              hold_req;
  logic [15:0]       bubble_cnt;

  logic              d2_valid, d2_rd_wren, d2_mem_rd, d2_mem_wren;
  logic [DATA_W-1:0] d2_pc, d2_rs1_data, d2_rs2_data, d2_imm;
  logic [CTRL_W-1:0] d2_ctrl;
  logic [RA_W-1:0]   d2_rs1, d2_rs2, d2_rd;
  logic              d2_hold_req;
  logic [1:0]        d2_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  id_ex_stage u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd_wren(id_rd_wren), .id_mem_rd(id_mem_rd), .id_mem_wren(id_mem_wren),
    .ex_stall(ex_stall), .flush(flush), .cnt_clr(cnt_clr),
    .ex_valid(ex_valid), .ex_rd_wren(ex_rd_wren), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wren(ex_mem_wren), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .hold_req(hold_req), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd_wren(id_rd_wren), .id_mem_rd(id_mem_rd), .id_mem_wren(id_mem_wren),
    .ex_stall(ex_stall), .flush(flush), .cnt_clr(cnt_clr),
    .ex_valid(d2_valid), .ex_rd_wren(d2_rd_wren), .ex_mem_rd(d2_mem_rd),
    .ex_mem_wren(d2_mem_wren), .ex_pc(d2_pc), .ex_rs1_data(d2_rs1_data),
    .ex_rs2_data(d2_rs2_data), .ex_imm(d2_imm), .ex_ctrl(d2_ctrl),
    .ex_rs1(d2_rs1), .ex_rs2(d2_rs2), .ex_rd(d2_rd),
    .hold_req(d2_hold_req), .bubble_cnt(d2_cnt)
  );

  // Payload data fields are derived from pc so one value identifies the instruction.
  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic wr,
                        input logic mr, input logic mw);
    id_valid = v;  id_pc = pc;
    id_rs1_data = pc + 32'h1000; id_rs2_data = pc + 32'h2000; id_imm = pc + 32'h3000;
    id_ctrl = pc[15:0] ^ 16'hA5A5;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd_wren = wr; id_mem_rd = mr; id_mem_wren = mw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
    step();
    n_checks++;
    if ({ex_valid, ex_rd_wren, ex_mem_rd, ex_mem_wren, ex_pc, ex_ctrl, ex_rd, bubble_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_hold: valid=%b pc=%h cnt=%0d expected all 0", ex_valid, ex_pc, bubble_cnt);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_mem_wren !== 1'b1 || ex_rs2_data !== 32'h2100) begin
      n_fail++; $display("FAIL first_load: valid=%b pc=%h mw=%b rs2d=%h expected 1 100 1 2100", ex_valid, ex_pc, ex_mem_wren, ex_rs2_data);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ex_valid, ex_rd_wren, ex_mem_wren, ex_pc, ex_imm, ex_rs1, ex_rd, bubble_cnt, hold_req} !== '0) begin
      n_fail++; $display("FAIL async_reset: valid=%b pc=%h imm=%h hold=%b expected 0", ex_valid, ex_pc, ex_imm, hold_req);
    end
    set_id(1'b1, 32'h140, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h140 || ex_rd !== 5'd6 || ex_rd_wren !== 1'b1) begin
      n_fail++; $display("FAIL resume_after_reset: valid=%b pc=%h rd=%0d expected 1 140 6", ex_valid, ex_pc, ex_rd);
    end
    exp_cnt = 16'd0;
  endtask

  task automatic test_load_use();
    set_id(1'b1, 32'h200, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 32'h204, 5'd3, 5'd5, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (hold_req !== 1'b1) begin
      n_fail++; $display("FAIL load_use_hold: hold_req=%b expected 1", hold_req);
    end
    step();
    exp_cnt = exp_cnt + 16'd1;
    n_checks++;
    if (ex_valid !== 1'b0 || ex_mem_rd !== 1'b0 || ex_rd_wren !== 1'b0 || ex_pc !== 32'h200 || bubble_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL load_use_bubble: valid=%b mr=%b pc=%h cnt=%0d expected 0 0 200 %0d", ex_valid, ex_mem_rd, ex_pc, bubble_cnt, exp_cnt);
    end
    n_checks++;
    if (hold_req !== 1'b0) begin
      n_fail++; $display("FAIL load_use_release: hold_req=%b expected 0", hold_req);
    end
    step();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h204 || ex_rs2 !== 5'd5 || bubble_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL load_use_retry: valid=%b pc=%h rs2=%0d cnt=%0d expected 1 204 5 %0d", ex_valid, ex_pc, ex_rs2, bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_x0_load();
    set_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 32'h304, 5'd0, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (hold_req !== 1'b0) begin
      n_fail++; $display("FAIL x0_hold: hold_req=%b expected 0", hold_req);
    end
    step();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h304 || bubble_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL x0_load: valid=%b pc=%h cnt=%0d expected 1 304 %0d", ex_valid, ex_pc, bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_invalid_id();
    set_id(1'b0, 32'h380, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
    step();
    n_checks++;
    if (ex_valid !== 1'b0 || ex_rd_wren !== 1'b0 || ex_mem_rd !== 1'b0 || ex_mem_wren !== 1'b0 || ex_pc !== 32'h380) begin
      n_fail++; $display("FAIL invalid_id: v=%b wr=%b mr=%b mw=%b pc=%h expected 0 0 0 0 380", ex_valid, ex_rd_wren, ex_mem_rd, ex_mem_wren, ex_pc);
    end
  endtask

  task automatic test_flush_vs_stall();
    set_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1);
    step();
    set_id(1'b1, 32'h404, 5'd7, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0);
    ex_stall = 1'b1; flush = 1'b1;
    #1;
    n_checks++;
    if (hold_req !== 1'b0) begin
      n_fail++; $display("FAIL flush_hold: hold_req=%b expected 0", hold_req);
    end
    step();
    exp_cnt = exp_cnt + 16'd1;
    ex_stall = 1'b0; flush = 1'b0;
    n_checks++;
    if (ex_valid !== 1'b0 || ex_mem_wren !== 1'b0 || ex_mem_rd !== 1'b0 || ex_rd_wren !== 1'b0 ||
        ex_pc !== 32'h400 || bubble_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL flush_kill: v=%b mw=%b pc=%h cnt=%0d expected 0 0 400 %0d", ex_valid, ex_mem_wren, ex_pc, bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_stall_hold();
    set_id(1'b1, 32'h500, 5'd12, 5'd13, 5'd14, 1'b1, 1'b0, 1'b1);
    step();
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(i[0], 32'h600 + 32'(i * 4), 5'(i), 5'(i + 1), 5'(i + 20), 1'b0, 1'b1, 1'b0);
      #1;
      n_checks++;
      if (hold_req !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold_req[%0d]: hold_req=%b expected 1", i, hold_req);
      end
      step();
      n_checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h500 || ex_rd !== 5'd14 || ex_mem_wren !== 1'b1 ||
          ex_mem_rd !== 1'b0 || ex_imm !== 32'h3500 || ex_ctrl !== (16'h0500 ^ 16'hA5A5) || bubble_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL stall_regs[%0d]: v=%b pc=%h rd=%0d mw=%b cnt=%0d expected 1 500 14 1 %0d", i, ex_valid, ex_pc, ex_rd, ex_mem_wren, bubble_cnt, exp_cnt);
      end
    end
    ex_stall = 1'b0;
    set_id(1'b1, 32'h700, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h700 || ex_mem_wren !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: v=%b pc=%h mw=%b expected 1 700 0", ex_valid, ex_pc, ex_mem_wren);
    end
  endtask

  task automatic test_counter_sat();
    logic [1:0] exp2 [5];
    exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3; exp2[4] = 2'd3;
    cnt_clr = 1'b1;
    step();
    exp_cnt = 16'd0;
    cnt_clr = 1'b0;
    n_checks++;
    if (d2_cnt !== 2'd0 || bubble_cnt !== 16'd0) begin
      n_fail++; $display("FAIL cnt_clear: small=%0d wide=%0d expected 0 0", d2_cnt, bubble_cnt);
    end
    flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (d2_cnt !== exp2[i] || bubble_cnt !== 16'(i + 1)) begin
        n_fail++; $display("FAIL cnt_sat[%0d]: small=%0d wide=%0d expected %0d %0d", i, d2_cnt, bubble_cnt, exp2[i], i + 1);
      end
    end
    cnt_clr = 1'b1;
    step();
    n_checks++;
    if (d2_cnt !== 2'd0 || bubble_cnt !== 16'd0 || ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL cnt_clr_vs_flush: small=%0d wide=%0d v=%b expected 0 0 0", d2_cnt, bubble_cnt, ex_valid);
    end
    flush = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_load();
    test_invalid_id();
    test_flush_vs_stall();
    test_stall_hold();
    test_counter_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of pc/operand/immediate payload fields.
REQ-002 Parameter CTRL_W, default 16, width of opaque control bundle (alu_op, op selects, wb_sel, imm selects, opcode).
REQ-003 Parameter RA_W, default 5, register-address width.
REQ-004 Parameter CNT_W, default 16, bubble-counter width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 id_valid  in  1  ID slot holds a real instruction.
REQ-008 id_pc, id_rs1_data, id_rs2_data, id_imm  in  DATA_W each  ID payload.
REQ-009 id_ctrl  in  CTRL_W  ID control bundle.
REQ-010 id_rs1, id_rs2, id_rd  in  RA_W each  source/destination register indices.
REQ-011 id_rd_wren, id_mem_rd, id_mem_wren  in  1 each  ID side-effect controls (mem_rd = load).
REQ-012 ex_stall  in  1  downstream cannot accept; EX must hold.
REQ-013 flush  in  1  branch/jump redirect; kill ID and EX contents.
REQ-014 cnt_clr  in  1  synchronous clear of bubble counter.
REQ-015 ex_valid, ex_rd_wren, ex_mem_rd, ex_mem_wren  out  1 each  registered EX controls.
REQ-016 ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  DATA_W each; ex_ctrl  out  CTRL_W; ex_rs1, ex_rs2, ex_rd  out  RA_W each  registered EX payload.
REQ-017 hold_req  out  1  combinational; IF/ID must not advance this cycle.
REQ-018 bubble_cnt  out  CNT_W  saturating count of inserted bubbles.

Function
REQ-019 Stage latency SHALL be one cycle: a loaded ID instruction appears on ex_* the cycle after the loading edge.
REQ-020 load_use SHALL be ex_valid & ex_mem_rd & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)), evaluated from current registers and current ID inputs.
REQ-021 hold_req SHALL equal ~flush & (ex_stall | load_use).
REQ-022 Per-edge update priority SHALL be: flush > ex_stall > load_use > normal load.
REQ-023 flush: ex_valid, ex_rd_wren, ex_mem_rd, ex_mem_wren SHALL become 0; payload fields SHALL hold; bubble_cnt increments.
REQ-024 ex_stall (no flush): every ex_* register SHALL hold its value; bubble_cnt unchanged.
REQ-025 load_use (no flush, no ex_stall): bubble inserted -- the four control bits SHALL become 0, payload holds, bubble_cnt increments; ID instruction retried next cycle.
REQ-026 Normal load: all ex_* SHALL take the ID values, with ex_rd_wren/ex_mem_rd/ex_mem_wren ANDed with id_valid and ex_valid = id_valid.
REQ-027 Side-effect outputs SHALL never be 1 while ex_valid is 0.
REQ-028 bubble_cnt SHALL saturate at 2^CNT_W-1 (no wrap); cnt_clr SHALL force 0 and takes priority over increment in the same cycle.
REQ-029 Index 0 destination SHALL never raise load_use.

Reset
REQ-030 While rst is high, all outputs SHALL be 0 (every ex_* field, ex_valid, bubble_cnt), immediately and independent of clk.
REQ-031 hold_req SHALL be 0 during reset (ex_valid=0 forces load_use=0) unless ex_stall is high.
REQ-032 Deassertion of rst mid-stream SHALL resume with a normal load on the first rising edge after release.

Verification
REQ-033 Reset: assert rst between edges with ex_valid=1 -> all outputs 0 before next edge; bubble_cnt=0.
REQ-034 Load-use: EX holds load ex_rd=5, ID has id_rs2=5, id_valid=1 -> hold_req=1, next cycle ex_valid=0, bubble_cnt=1; following cycle ID instruction loaded, ex_valid=1.
REQ-035 x0 load: EX load ex_rd=0, id_rs1=0 -> hold_req=0, normal load, bubble_cnt unchanged.
REQ-036 Flush vs stall: flush=1 with ex_stall=1 and load_use true -> hold_req=0, ex_valid=0, ex_mem_wren=0, bubble_cnt+1.
REQ-037 Stall hold: ex_stall=1 for 3 cycles with changing ID inputs -> all ex_* constant, hold_req=1, bubble_cnt unchanged.
REQ-038 Counter: CNT_W=2, 5 consecutive flushes -> bubble_cnt 1,2,3,3,3; cnt_clr with flush -> 0.
